// File: rtl/cnn_wram_arbiter_if.sv
// Bundle for the weight-RAM arbiter: host write port, engine read port, RAM macro port.
// The master side is the loader, the engine and the RAM macro; the slave side is the arbiter.
interface cnn_wram_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 8
);
   logic              host_valid;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ready;
   logic              eng_req;
   logic [ADDR_W-1:0] eng_addr;
   logic              eng_last;
   logic              eng_gnt;
   logic [DATA_W-1:0] eng_rdata;
   logic              eng_rvalid;
   logic              compute_busy;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_wren;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      output host_valid, host_addr, host_wdata, eng_req, eng_addr, eng_last,
             compute_busy, ram_rdata,
      input  host_ready, eng_gnt, eng_rdata, eng_rvalid, ram_addr, ram_wdata, ram_wren
   );

   modport slave (
      input  host_valid, host_addr, host_wdata, eng_req, eng_addr, eng_last,
             compute_busy, ram_rdata,
      output host_ready, eng_gnt, eng_rdata, eng_rvalid, ram_addr, ram_wdata, ram_wren
   );
endinterface

// File: rtl/cnn_wram_arbiter.sv
// Arbitrates one single-port weight RAM between host writes and engine read bursts.
// Optional stall statistics are enabled by defining CNN_WRAM_ARB_STATS_EN.
module cnn_wram_arbiter #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 8,
   parameter int READ_LAT  = 2,
   parameter int MAX_WAIT  = 8,
   parameter int BURST_MAX = 16
) (
   input  logic        clk,
   input  logic        reset,
`ifdef CNN_WRAM_ARB_STATS_EN
   input  logic        stat_clr,
   output logic [15:0] stat_host_stall,
   output logic [15:0] stat_eng_stall,
`endif
   cnn_wram_arbiter_if.slave bus
);
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   localparam int BEAT_W = $clog2(BURST_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);
   localparam logic [BEAT_W-1:0] BEAT_LIM = BEAT_W'(BURST_MAX);

   typedef enum logic [1:0] {IDLE, HOST, ENG} state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] host_wait_q, host_wait_d, eng_wait_q, eng_wait_d;
   logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
   logic              host_ready, eng_gnt, host_starved, eng_starved;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d, eng_rdata_q;
   logic              ram_wren_q;
   logic              rv_q [READ_LAT+1];

   assign host_starved = (host_wait_q == WAIT_SAT);
   assign eng_starved  = (eng_wait_q == WAIT_SAT);
   assign beat_inc     = beat_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      host_ready = 1'b0;
      eng_gnt    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.host_valid && bus.eng_req) begin
               if (eng_starved || (!host_starved && bus.compute_busy)) eng_gnt = 1'b1;
               else host_ready = 1'b1;
            end else begin
               host_ready = bus.host_valid;
               eng_gnt    = bus.eng_req;
            end
         end
         HOST: begin
            if (bus.eng_req && eng_starved) eng_gnt = 1'b1;
            else if (bus.host_valid) host_ready = 1'b1;
            else state_d = IDLE;
         end
         ENG: begin
            // The host is never served mid-burst; BURST_MAX bounds its latency.
            if (bus.eng_req) eng_gnt = 1'b1;
            else begin
               state_d = IDLE;
               beat_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase
      if (host_ready) state_d = HOST;
      if (eng_gnt) begin
         beat_d = (state_q == ENG) ? beat_inc : BEAT_W'(1);
         if (bus.eng_last || beat_d == BEAT_LIM) begin
            state_d = IDLE;
            beat_d  = '0;
         end else begin
            state_d = ENG;
         end
      end
   end

   always_comb begin
      host_wait_d = '0;
      eng_wait_d  = '0;
      if (bus.host_valid && !host_ready)
         host_wait_d = host_starved ? host_wait_q : host_wait_q + 1'b1;
      if (bus.eng_req && !eng_gnt)
         eng_wait_d = eng_starved ? eng_wait_q : eng_wait_q + 1'b1;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      if (host_ready) begin
         ram_addr_d  = bus.host_addr;
         ram_wdata_d = bus.host_wdata;
      end else if (eng_gnt) begin
         ram_addr_d  = bus.eng_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         host_wait_q <= '0;
         eng_wait_q  <= '0;
         beat_q      <= '0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_wren_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         host_wait_q <= host_wait_d;
         eng_wait_q  <= eng_wait_d;
         beat_q      <= beat_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_wren_q  <= host_ready;
      end
   end

   // Read-return tracker: stage k is set k+1 cycles after a grant.
   always_ff @(posedge clk) begin
      if (reset) rv_q[0] <= 1'b0;
      else       rv_q[0] <= eng_gnt;
   end

   generate
      for (genvar gi = 1; gi <= READ_LAT; gi++) begin : g_rv
         always_ff @(posedge clk) begin
            if (reset) rv_q[gi] <= 1'b0;
            else       rv_q[gi] <= rv_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset)                   eng_rdata_q <= '0;
      else if (rv_q[READ_LAT-1])   eng_rdata_q <= bus.ram_rdata;
   end

   assign bus.host_ready = host_ready;
   assign bus.eng_gnt    = eng_gnt;
   assign bus.eng_rdata  = eng_rdata_q;
   assign bus.eng_rvalid = rv_q[READ_LAT];
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = ram_wdata_q;
   assign bus.ram_wren   = ram_wren_q;

`ifdef CNN_WRAM_ARB_STATS_EN
   logic [15:0] host_stall_q, eng_stall_q;

   always_ff @(posedge clk) begin
      if (reset || stat_clr) begin
         host_stall_q <= '0;
         eng_stall_q  <= '0;
      end else begin
         if (bus.host_valid && !host_ready && host_stall_q != 16'hFFFF)
            host_stall_q <= host_stall_q + 16'd1;
         if (bus.eng_req && !eng_gnt && eng_stall_q != 16'hFFFF)
            eng_stall_q <= eng_stall_q + 16'd1;
      end
   end

   assign stat_host_stall = host_stall_q;
   assign stat_eng_stall  = eng_stall_q;
`endif
endmodule

// File: tb/tb_cnn_wram_arbiter.sv
// Directed bench for cnn_wram_arbiter: writes, bursts, arbitration, starvation, reset, stats.
// Stall statistics are exercised when CNN_WRAM_ARB_STATS_EN is defined.
module tb_cnn_wram_arbiter;
   logic clk;
   logic reset;
   int   vecs = 0;
   int   errs = 0;

   cnn_wram_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus ();

`ifdef CNN_WRAM_ARB_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_host_stall, stat_eng_stall;
`endif

   cnn_wram_arbiter #(
      .ADDR_W(15), .DATA_W(8), .READ_LAT(2), .MAX_WAIT(8), .BURST_MAX(16)
   ) dut (
      .clk             (clk),
      .reset           (reset),
`ifdef CNN_WRAM_ARB_STATS_EN
      .stat_clr        (stat_clr),
      .stat_host_stall (stat_host_stall),
      .stat_eng_stall  (stat_eng_stall),
`endif
      .bus             (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: data for the registered address appears one edge later, low address byte.
   always @(posedge clk) bus.ram_rdata <= bus.ram_addr[7:0];

   task automatic drive_idle();
      bus.host_valid   = 1'b0;
      bus.host_addr    = '0;
      bus.host_wdata   = '0;
      bus.eng_req      = 1'b0;
      bus.eng_addr     = '0;
      bus.eng_last     = 1'b0;
      bus.compute_busy = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         drive_idle();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_idle();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      vecs++; if (bus.host_ready !== 1'b0) begin errs++; $display("FAIL reset.host_ready got %b want 0", bus.host_ready); end
      vecs++; if (bus.eng_gnt !== 1'b0) begin errs++; $display("FAIL reset.eng_gnt got %b want 0", bus.eng_gnt); end
      vecs++; if (bus.eng_rvalid !== 1'b0) begin errs++; $display("FAIL reset.eng_rvalid got %b want 0", bus.eng_rvalid); end
      vecs++; if (bus.eng_rdata !== 8'h00) begin errs++; $display("FAIL reset.eng_rdata got %h want 00", bus.eng_rdata); end
      vecs++; if (bus.ram_addr !== 15'h0) begin errs++; $display("FAIL reset.ram_addr got %h want 0", bus.ram_addr); end
      vecs++; if (bus.ram_wdata !== 8'h00) begin errs++; $display("FAIL reset.ram_wdata got %h want 00", bus.ram_wdata); end
      vecs++; if (bus.ram_wren !== 1'b0) begin errs++; $display("FAIL reset.ram_wren got %b want 0", bus.ram_wren); end
      $display("reset released");
   endtask

   task automatic test_host_write();
      int p;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         bus.host_valid = (c < 4);
         bus.host_addr  = 15'(c);
         bus.host_wdata = 8'hA0 + 8'(c);
         #1;
         p = (c == 0) ? 0 : ((c - 1 > 3) ? 3 : c - 1);
         vecs++;
         if ({bus.host_ready, bus.eng_gnt} !== {1'(c < 4), 1'b0}) begin
            errs++; $display("FAIL host_write.grant c=%0d got %b%b want %b0", c, bus.host_ready, bus.eng_gnt, c < 4);
         end
         vecs++;
         if (bus.ram_wren !== 1'((c >= 1) && (c <= 4)) || bus.ram_addr !== 15'(p)
             || bus.ram_wdata !== ((c == 0) ? 8'h00 : 8'hA0 + 8'(p))) begin
            errs++; $display("FAIL host_write.ram c=%0d got wren=%b addr=%h data=%h want addr=%h",
                             c, bus.ram_wren, bus.ram_addr, bus.ram_wdata, p);
         end
         $display("host_write c=%0d ready=%b wren=%b addr=%h wdata=%h", c, bus.host_ready,
                  bus.ram_wren, bus.ram_addr, bus.ram_wdata);
      end
      idle_cycles(2);
   endtask

   task automatic test_eng_burst();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         drive_idle();
         bus.eng_req    = (c < 3);
         bus.eng_addr   = 15'(10 + c);
         bus.eng_last   = (c == 2);
         bus.host_valid = (c == 3);  // only served if the burst has returned to IDLE
         bus.host_addr  = 15'h55;
         bus.host_wdata = 8'h5A;
         #1;
         vecs++;
         if ({bus.host_ready, bus.eng_gnt} !== {1'(c == 3), 1'(c < 3)}) begin
            errs++; $display("FAIL eng_burst.grant c=%0d got ready=%b gnt=%b", c, bus.host_ready, bus.eng_gnt);
         end
         vecs++;
         if (bus.eng_rvalid !== 1'((c >= 3) && (c <= 5))) begin
            errs++; $display("FAIL eng_burst.rvalid c=%0d got %b want %b", c, bus.eng_rvalid, (c >= 3) && (c <= 5));
         end
         if (c >= 3 && c <= 5) begin
            vecs++;
            if (bus.eng_rdata !== 8'(10 + c - 3)) begin
               errs++; $display("FAIL eng_burst.rdata c=%0d got %0d want %0d", c, bus.eng_rdata, 10 + c - 3);
            end
         end
         $display("eng_burst c=%0d gnt=%b rvalid=%b rdata=%0d", c, bus.eng_gnt, bus.eng_rvalid, bus.eng_rdata);
      end
      idle_cycles(3);
   endtask

   task automatic test_arb_host_first();
      logic [1:0] exp_rg;
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         bus.compute_busy = 1'b0;
         bus.host_valid   = 1'b1;
         bus.host_addr    = 15'h200 + 15'(c);
         bus.host_wdata   = 8'(c);
         bus.eng_req      = 1'b1;
         bus.eng_addr     = 15'h100 + 15'(c);
         bus.eng_last     = (c == 9);
         #1;
         exp_rg = (c == 8 || c == 9) ? 2'b01 : 2'b10;
         vecs++;
         if ({bus.host_ready, bus.eng_gnt} !== exp_rg) begin
            errs++; $display("FAIL arb_host_first c=%0d got %b%b want %b", c, bus.host_ready, bus.eng_gnt, exp_rg);
         end
         $display("arb_host_first c=%0d ready=%b gnt=%b", c, bus.host_ready, bus.eng_gnt);
      end
      idle_cycles(5);
   endtask

   task automatic test_burst_limit();
      logic [1:0] exp_rg;
      for (int c = 0; c < 18; c++) begin
         @(negedge clk);
         bus.compute_busy = 1'b1;
         bus.host_valid   = 1'b1;
         bus.host_addr    = 15'h300 + 15'(c);
         bus.host_wdata   = 8'(c);
         bus.eng_req      = 1'b1;
         bus.eng_addr     = 15'h40 + 15'(c);
         bus.eng_last     = 1'b0;
         #1;
         exp_rg = (c < 16) ? 2'b01 : 2'b10;
         vecs++;
         if ({bus.host_ready, bus.eng_gnt} !== exp_rg) begin
            errs++; $display("FAIL burst_limit c=%0d got %b%b want %b", c, bus.host_ready, bus.eng_gnt, exp_rg);
         end
         $display("burst_limit c=%0d ready=%b gnt=%b", c, bus.host_ready, bus.eng_gnt);
      end
      idle_cycles(5);
   endtask

   task automatic test_reset_mid_burst();
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         drive_idle();
         reset        = (c == 2);
         bus.eng_req  = (c < 2) || (c == 7);
         bus.eng_addr = (c == 7) ? 15'd5 : 15'(20 + c);
         bus.eng_last = (c == 7);
         #1;
         if (c < 2 || c == 7) begin
            vecs++;
            if (bus.eng_gnt !== 1'b1 || bus.host_ready !== 1'b0) begin
               errs++; $display("FAIL reset_mid.grant c=%0d got gnt=%b ready=%b want gnt=1", c, bus.eng_gnt, bus.host_ready);
            end
         end
         if (c >= 3 && c <= 6) begin
            vecs++;
            if ({bus.eng_rvalid, bus.eng_rdata, bus.ram_addr, bus.ram_wdata, bus.ram_wren,
                 bus.eng_gnt, bus.host_ready} !== '0) begin
               errs++; $display("FAIL reset_mid.zero c=%0d got rvalid=%b rdata=%h addr=%h wren=%b gnt=%b",
                                c, bus.eng_rvalid, bus.eng_rdata, bus.ram_addr, bus.ram_wren, bus.eng_gnt);
            end
         end
         if (c >= 8) begin
            vecs++;
            if (bus.eng_rvalid !== 1'(c == 10)) begin
               errs++; $display("FAIL reset_mid.rvalid c=%0d got %b want %b", c, bus.eng_rvalid, c == 10);
            end
         end
         if (c == 10) begin
            vecs++;
            if (bus.eng_rdata !== 8'd5) begin
               errs++; $display("FAIL reset_mid.rdata got %0d want 5", bus.eng_rdata);
            end
         end
         $display("reset_mid c=%0d reset=%b gnt=%b rvalid=%b rdata=%0d", c, reset, bus.eng_gnt,
                  bus.eng_rvalid, bus.eng_rdata);
      end
      reset = 1'b0;
      idle_cycles(2);
   endtask

`ifdef CNN_WRAM_ARB_STATS_EN
   task automatic test_stats();
      @(negedge clk);
      drive_idle();
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         bus.compute_busy = 1'b1;
         bus.host_valid   = (c < 6);
         bus.host_addr    = 15'h7;
         bus.host_wdata   = 8'h77;
         bus.eng_req      = (c < 5);
         bus.eng_addr     = 15'(c);
         bus.eng_last     = (c == 4);
         #1;
         $display("stats c=%0d ready=%b gnt=%b host_stall=%0d", c, bus.host_ready, bus.eng_gnt, stat_host_stall);
      end
      vecs++;
      if (stat_host_stall !== 16'd5) begin
         errs++; $display("FAIL stats.host_stall got %0d want 5", stat_host_stall);
      end
      vecs++;
      if (stat_eng_stall !== 16'd0) begin
         errs++; $display("FAIL stats.eng_stall got %0d want 0", stat_eng_stall);
      end
      @(negedge clk);
      drive_idle();
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0;
      #1;
      vecs++;
      if (stat_host_stall !== 16'd0) begin
         errs++; $display("FAIL stats.clr got %0d want 0", stat_host_stall);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog expired: vecs=%0d", vecs);
      $fatal(1, "watchdog");
   end

   initial begin
`ifdef CNN_WRAM_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      test_reset();
      test_host_write();
      test_eng_burst();
      test_arb_host_first();
      test_burst_limit();
      test_reset_mid_burst();
`ifdef CNN_WRAM_ARB_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
